// File: rtl/uart_cmd_host.sv
// uart_cmd_host: serialises a command (opcode + operands) into a framed byte
// stream for a UART transmitter, then optionally collects a DATA_WIDTH response
// from the UART receiver with a per-byte inactivity timeout.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   cmd_valid_i/cmd_ready_o            command handshake
//   cmd_opcode_i, cmd_nops_i,
//   cmd_operands_i, cmd_resp_en_i      command fields
//   tx_data_o/tx_valid_o/tx_ready_i    outgoing byte stream
//   rx_data_i/rx_valid_i/rx_ready_o    incoming byte stream
//   resp_data_o/resp_timeout_o/
//   resp_valid_o/resp_ready_i          result handshake
//   busy_o                             high whenever not idle
module uart_cmd_host #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_OPS        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [7:0]                         cmd_opcode_i,
  input  logic [$clog2(MAX_OPS+1)-1:0]       cmd_nops_i,
  input  logic [MAX_OPS*DATA_WIDTH-1:0]      cmd_operands_i,
  input  logic                               cmd_resp_en_i,
  output logic [7:0]                         tx_data_o,
  output logic                               tx_valid_o,
  input  logic                               tx_ready_i,
  input  logic [7:0]                         rx_data_i,
  input  logic                               rx_valid_i,
  output logic                               rx_ready_o,
  output logic [DATA_WIDTH-1:0]              resp_data_o,
  output logic                               resp_timeout_o,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic                               busy_o
);

  localparam int unsigned NOPS_W = $clog2(MAX_OPS + 1);
  localparam int unsigned OPS_W  = MAX_OPS * DATA_WIDTH;
  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned RXC_W  = $clog2(BPW) + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    WAIT_RSP,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [OPS_W-1:0]       ops_q, ops_d;
  logic                   resp_en_q, resp_en_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [RXC_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]        tmo_q, tmo_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   resp_timeout_q, resp_timeout_d;
  logic                   resp_valid_q, resp_valid_d;

  logic [NOPS_W-1:0]      nops_clamp;
  logic                   tx_hs;

  // Operand count saturates at MAX_OPS.
  always_comb begin
    nops_clamp = cmd_nops_i;
    if (cmd_nops_i > NOPS_W'(MAX_OPS)) begin
      nops_clamp = NOPS_W'(MAX_OPS);
    end
  end

  assign tx_hs = tx_valid_q && tx_ready_i;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    ops_d          = ops_q;
    resp_en_d      = resp_en_q;
    len_d          = len_q;
    idx_d          = idx_q;
    rx_cnt_d       = rx_cnt_q;
    tmo_d          = tmo_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    resp_valid_d   = resp_valid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d        = HDR;
          ops_d          = cmd_operands_i;
          resp_en_d      = cmd_resp_en_i;
          len_d          = LEN_W'(4) + LEN_W'(nops_clamp) * LEN_W'(BPW);
          idx_d          = '0;
          tx_valid_d     = 1'b1;
          tx_data_d      = cmd_opcode_i;
          resp_data_d    = '0;
          resp_timeout_d = 1'b0;
        end
      end

      // tx_data_q always holds byte idx_q; the next byte is loaded on handshake.
      HDR, PAYLOAD: begin
        if (tx_hs) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            if (resp_en_q) begin
              state_d  = WAIT_RSP;
              tmo_d    = '0;
              rx_cnt_d = '0;
            end else begin
              state_d      = DONE;
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
            end
          end else begin
            idx_d = idx_q + LEN_W'(1);
            if (idx_q < LEN_W'(3)) begin
              state_d = HDR;
              case (idx_q[1:0])
                2'd0:    tx_data_d = 8'h00;
                2'd1:    tx_data_d = len_q[7:0];
                default: tx_data_d = len_q[15:8];
              endcase
            end else begin
              // Operands are consumed from a shift register, LSB first.
              state_d   = PAYLOAD;
              tx_data_d = ops_q[7:0];
              ops_d     = ops_q >> 8;
            end
          end
        end
      end

      // An accepted byte takes priority over a coincident timeout.
      WAIT_RSP: begin
        if (rx_valid_i) begin
          resp_data_d[{rx_cnt_q, 3'b000} +: 8] = rx_data_i;
          tmo_d    = '0;
          rx_cnt_d = rx_cnt_q + RXC_W'(1);
          if (rx_cnt_q == RXC_W'(BPW - 1)) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end
        end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d        = DONE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end

      DONE: begin
        if (resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      ops_q          <= '0;
      resp_en_q      <= 1'b0;
      len_q          <= '0;
      idx_q          <= '0;
      rx_cnt_q       <= '0;
      tmo_q          <= '0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
      resp_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ops_q          <= ops_d;
      resp_en_q      <= resp_en_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      rx_cnt_q       <= rx_cnt_d;
      tmo_q          <= tmo_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      resp_valid_q   <= resp_valid_d;
    end
  end

  // Stray bytes are always drained, so the receiver is never back-pressured.
  assign rx_ready_o     = 1'b1;
  assign cmd_ready_o    = cmd_ready_q;
  assign busy_o         = busy_q;
  assign tx_data_o      = tx_data_q;
  assign tx_valid_o     = tx_valid_q;
  assign resp_data_o    = resp_data_q;
  assign resp_timeout_o = resp_timeout_q;
  assign resp_valid_o   = resp_valid_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host: table of commands with expected responses, a tx/resp
// scoreboard fed when each command is driven, and hand sequences for reset.
module tb_uart_cmd_host;

  localparam int unsigned DW  = 32;
  localparam int unsigned MO  = 8;
  localparam int unsigned TMO = 50;
  localparam int unsigned NW  = $clog2(MO + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_opcode = 8'h00;
  logic [NW-1:0]     cmd_nops = '0;
  logic [MO*DW-1:0]  cmd_operands = '0;
  logic              cmd_resp_en = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [DW-1:0]     resp_data;
  logic              resp_to;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              busy;

  uart_cmd_host #(.DATA_WIDTH(DW), .MAX_OPS(MO), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_nops_i(cmd_nops),
    .cmd_operands_i(cmd_operands), .cmd_resp_en_i(cmd_resp_en),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .resp_data_o(resp_data), .resp_timeout_o(resp_to),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_hs = 0;

  logic [7:0]  exp_tx[$];
  logic [DW:0] exp_resp[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]       op;
    int               nops;
    logic [MO*DW-1:0] ops;
    logic             resp_en;
    logic             toggle;
    logic             stray;
    int               rx_n;
    logic [31:0]      rx;
    logic [DW-1:0]    exp_data;
    logic             exp_to;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input int nops, input logic resp_en,
                              input logic toggle, input logic stray, input int rx_n,
                              input logic [31:0] rx, input logic [DW-1:0] exp_data,
                              input logic exp_to);
    vec_t v;
    v.op = op; v.nops = nops; v.ops = '0; v.resp_en = resp_en; v.toggle = toggle;
    v.stray = stray; v.rx_n = rx_n; v.rx = rx; v.exp_data = exp_data; v.exp_to = exp_to;
    return v;
  endfunction

  // Expected frame: opcode, 00, L lo, L hi, then operands LSB first.
  task automatic push_tx(input vec_t v);
    int n;
    logic [15:0] len;
    n = (v.nops > int'(MO)) ? int'(MO) : v.nops;
    len = 16'(4 + n * (DW / 8));
    exp_tx.push_back(v.op);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(len[7:0]);
    exp_tx.push_back(len[15:8]);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < int'(DW / 8); j++)
        exp_tx.push_back(v.ops[i*DW + j*8 +: 8]);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  logic       held = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [DW:0] r;
    if (!rst_n) begin
      held = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk("rx_ready_high", 64'(rx_ready), 64'd1);
      if (held) chk("tx_stable_in_stall", 64'(tx_data), 64'(held_data));
      if (prev_valid && exp_tx.size() > 0) chk("tx_no_bubble", 64'(tx_valid), 64'd1);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_byte", 64'(tx_data), 64'(e));
          tx_hs++;
        end
      end
      held = tx_valid && !tx_ready;
      held_data = tx_data;
      prev_valid = tx_valid;
      if (resp_valid && resp_ready) begin
        if (exp_resp.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=%0h expected=none", resp_data);
        end else begin
          r = exp_resp.pop_front();
          chk("resp_data", 64'(resp_data), 64'(r[DW-1:0]));
          chk("resp_timeout", 64'(resp_to), 64'(r[DW]));
        end
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_resp_to"}, 64'(resp_to), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic drive_cmd(input vec_t v);
    @(posedge clk); #2;
    cmd_opcode = v.op; cmd_nops = NW'(v.nops); cmd_operands = v.ops;
    cmd_resp_en = v.resp_en; cmd_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk); #1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    int k;
    int t0;
    logic seen;
    push_tx(v);
    exp_resp.push_back({v.exp_to, v.exp_data});
    drive_cmd(v);
    if (v.stray) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
    @(negedge clk); #1;
    chk("first_tx_latency", 64'(tx_valid), 64'd1);
    chk("busy_active", 64'(busy), 64'd1);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    k = 0;
    while (exp_tx.size() > 0 && k < 2000) begin
      @(posedge clk); #2;
      k++;
      tx_ready = v.toggle ? !tx_ready : 1'b1;
      if (v.stray) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
      @(negedge clk); #1;
    end
    if (exp_tx.size() > 0) begin
      checks++; failures++;
      $display("FAIL tx_drain_bound actual=%0d_left expected=0_left", exp_tx.size());
      exp_tx.delete();
    end
    @(posedge clk); #2;
    rx_valid = 1'b0; tx_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < v.rx_n; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      rx_valid = 1'b1; rx_data = v.rx[i*8 +: 8]; t0 = cyc;
    end
    if (v.rx_n > 0) begin @(posedge clk); #2; rx_valid = 1'b0; end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      seen = resp_valid;
    end
    chk("resp_valid_seen", 64'(seen), 64'd1);
    if (seen && v.exp_to && v.rx_n > 0)
      chk("timeout_latency", 64'(cyc - t0), 64'(TMO + 1));
    // Hold off the response and require it to stay put.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("resp_hold_valid", 64'(resp_valid), 64'd1);
      chk("resp_hold_data", 64'(resp_data), 64'(v.exp_data));
      chk("resp_hold_to", 64'(resp_to), 64'(v.exp_to));
    end
    @(posedge clk); #2; resp_ready = 1'b1;
    @(posedge clk); #2; resp_ready = 1'b0;
    @(negedge clk); #1;
    chk("back_idle_ready", 64'(cmd_ready), 64'd1);
    chk("back_idle_busy", 64'(busy), 64'd0);
    chk("back_idle_resp_valid", 64'(resp_valid), 64'd0);
    if (exp_resp.size() > 0) begin
      checks++; failures++;
      $display("FAIL resp_missing actual=%0d_pending expected=0_pending", exp_resp.size());
      exp_resp.delete();
    end
  endtask

  vec_t vecs[7];

  initial begin
    vec_t rv;
    vecs[0] = mk(8'h10, 2, 1'b1, 1'b0, 1'b0, 4, 32'h0000_0007, 32'h0000_0007, 1'b0);
    vecs[0].ops[31:0] = 32'd3; vecs[0].ops[63:32] = 32'd4;
    vecs[1] = vecs[0]; vecs[1].toggle = 1'b1;
    vecs[2] = mk(8'h22, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b0);
    vecs[3] = mk(8'h33, 1, 1'b1, 1'b0, 1'b0, 1, 32'h0000_00AB, 32'h0000_00AB, 1'b1);
    vecs[3].ops[31:0] = 32'h1122_3344;
    vecs[4] = mk(8'h44, 9, 1'b1, 1'b0, 1'b1, 4, 32'hEFBE_ADDE, 32'hEFBE_ADDE, 1'b0);
    for (int i = 0; i < int'(MO); i++) vecs[4].ops[i*DW +: DW] = 32'hA0B0_C0D0 + 32'(i);
    vecs[5] = mk(8'h55, 1, 1'b1, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b1);
    vecs[5].ops[31:0] = 32'hCAFE_F00D;
    vecs[6] = mk(8'h66, 3, 1'b1, 1'b1, 1'b0, 2, 32'h0000_0201, 32'h0000_0201, 1'b1);
    vecs[6].ops[95:0] = 96'h0C0B0A09_08070605_04030201;

    @(negedge clk); #1;
    chk_reset_outs("rst_hold");
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk); #1;
    chk_reset_outs("rst_release");

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset in the middle of a frame aborts it.
    rv = vecs[0];
    push_tx(rv);
    tx_hs = 0;
    drive_cmd(rv);
    for (int i = 0; i < 50 && tx_hs < 5; i++) begin @(negedge clk); #1; end
    chk("pre_reset_tx_count", 64'(tx_hs), 64'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_tx.delete(); exp_resp.delete();
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; chk_reset_outs("mid_rst"); end
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    end
    run_cmd(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_host.md
UART_CMD_HOST -- requirements
Module: uart_cmd_host

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand/response word width; it is a multiple of 8, range 8..64.
REQ-002 Parameter MAX_OPS, default 8, SHALL set the maximum number of operands per command, range 1..32.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the response timeout in clk_i cycles, range >= 2.
REQ-004 clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1  command handshake; transfer occurs when both are high.
REQ-007 cmd_opcode_i  in  8  opcode byte.
REQ-008 cmd_nops_i  in  $clog2(MAX_OPS+1)  operand count.
REQ-009 cmd_operands_i  in  MAX_OPS*DATA_WIDTH  operand k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 cmd_resp_en_i  in  1  1 = a DATA_WIDTH response is expected, 0 = no response.
REQ-011 tx_data_o / tx_valid_o / tx_ready_i  out/out/in  8/1/1  byte stream to the UART transmitter.
REQ-012 rx_data_i / rx_valid_i / rx_ready_o  in/in/out  8/1/1  byte stream from the UART receiver.
REQ-013 resp_data_o / resp_timeout_o / resp_valid_o / resp_ready_i  out/out/out/in  DATA_WIDTH/1/1/1  result handshake.
REQ-014 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL use FSM states IDLE, HDR, PAYLOAD, WAIT_RSP, DONE.
REQ-016 IDLE: cmd_ready_o=1; on a command handshake, all command fields SHALL be registered and the FSM SHALL go to HDR.
REQ-017 nops SHALL be taken as min(cmd_nops_i, MAX_OPS).
REQ-018 Packet length L SHALL be 4 + nops*DATA_WIDTH/8, computed as 16 bits.
REQ-019 HDR SHALL emit 4 bytes in order: opcode, 0x00, L[7:0], L[15:8].
REQ-020 PAYLOAD SHALL emit operands 0..nops-1, each least-significant byte first; with nops=0 PAYLOAD SHALL be skipped.
REQ-021 A byte SHALL advance only on a cycle with tx_valid_o && tx_ready_i.
REQ-022 tx_data_o SHALL be stable while tx_valid_o=1 && tx_ready_i=0.
REQ-023 tx_valid_o SHALL be high every cycle in HDR and PAYLOAD, with no bubbles between bytes.
REQ-024 After the last byte: if resp_en=1 the FSM SHALL go to WAIT_RSP and clear the timeout counter; otherwise it SHALL go to DONE with resp_data_o=0.
REQ-025 WAIT_RSP: rx_ready_o=1; DATA_WIDTH/8 bytes SHALL be accepted, assembled least-significant byte first, then the FSM SHALL go to DONE.
REQ-026 The timeout counter SHALL reset to 0 on each accepted rx byte.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 with no byte, the FSM SHALL go to DONE with resp_timeout_o=1 and resp_data_o holding the partial bytes (unreceived bytes = 0).
REQ-028 DONE: resp_valid_o=1 with resp_data_o and resp_timeout_o stable until resp_ready_i; on the handshake cycle the FSM SHALL return to IDLE.
REQ-029 First-command latency: the first tx_valid_o SHALL occur the cycle after the command handshake.
REQ-030 In IDLE, HDR, PAYLOAD and DONE, rx_ready_o SHALL be 1 and stray rx bytes SHALL be discarded.
REQ-031 cmd_ready_o SHALL be 0 in every state except IDLE.
REQ-032 Simultaneous rx byte acceptance and timeout in the same cycle: the byte SHALL win and the timeout SHALL not fire.

Reset
REQ-033 While rst_ni=0, and for the first edge after its release, the block SHALL be in IDLE with outputs: cmd_ready_o=1, tx_valid_o=0, tx_data_o=0, rx_ready_o=1, resp_valid_o=0, resp_data_o=0, resp_timeout_o=0, busy_o=0.
REQ-034 Reset asserted mid-packet or mid-response SHALL abort the operation immediately, with no further tx bytes and no resp_valid_o.

Verification (DATA_WIDTH=32)
REQ-035 Command opcode=0x10, nops=2, operands 3,4, resp_en=1, tx_ready_i always 1 -> tx bytes 10 00 0C 00 03 00 00 00 04 00 00 00 on 12 consecutive cycles; then rx bytes 07 00 00 00 -> resp_data_o=0x00000007, resp_timeout_o=0.
REQ-036 Same command with tx_ready_i toggling 1/0 every cycle -> identical byte sequence, tx_data_o stable during each stall.
REQ-037 Command with nops=0, resp_en=0 -> 4 bytes op 00 04 00, then resp_valid_o with resp_data_o=0 and timeout=0.
REQ-038 TIMEOUT_CYCLES=50; after tx, only rx byte 0xAB is sent -> timeout 50 cycles after that byte, resp_data_o=0x000000AB, resp_timeout_o=1.
REQ-039 cmd_nops_i=9 with MAX_OPS=8 -> L=0x0024, exactly 8 operands sent.
REQ-040 rst_ni pulsed low after the 5th tx byte -> tx_valid_o=0 and resp_valid_o=0 during reset; the next command completes normally.
